fetch_sequencer: RTL and testbench



---
 rtl/seq_pkg.sv | 19 +
 rtl/pc_next.sv | 45 ++++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the program-fetch sequencer.
//   seq_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   pc_sel_t    : next-PC source chosen by the FSM and evaluated by pc_next
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_ABS  = 2'd1,
      PC_REL  = 2'd2,
      PC_INC  = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC calculator.
// Ports:
//   prog_ctr  in  D  current fetch address
//   target    in  D  absolute jump address or signed relative offset
//   sel       in  2  next-PC source (pc_sel_t)
//   next_pc   out D  candidate next address (equals prog_ctr on wrap)
//   wrap_err  out 1  relative jump or increment left the range [0, 2^D-1]
module pc_next
   import seq_pkg::*;
#(
   parameter int D = 12
) (
   input  logic [D-1:0] prog_ctr,
   input  logic [D-1:0] target,
   input  pc_sel_t      sel,
   output logic [D-1:0] next_pc,
   output logic         wrap_err
);

   logic [D:0] w_sum;

   // Sums are formed one bit wider than the PC. With an unsigned PC and a
   // sign-extended offset, any result outside [0, 2^D-1] sets bit D, both
   // for overflow and for underflow.
   always_comb begin
      w_sum    = '0;
      next_pc  = prog_ctr;
      wrap_err = 1'b0;
      case (sel)
         PC_ABS: next_pc = target;
         PC_REL: begin
            w_sum    = {1'b0, prog_ctr} + {target[D-1], target};
            wrap_err = w_sum[D];
            if (!w_sum[D]) next_pc = w_sum[D-1:0];
         end
         PC_INC: begin
            w_sum    = {1'b0, prog_ctr} + {{D{1'b0}}, 1'b1};
            wrap_err = w_sum[D];
            if (!w_sum[D]) next_pc = w_sum[D-1:0];
         end
         default: next_pc = prog_ctr;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-fetch sequencer: starts one of P stored programs on req, steps the
// fetch address with stall / jump / halt handling, and reports sticky
// done/error plus a saturating run-cycle count.
// Handshake: req is a one-cycle request with no ready; it is accepted on any
// rising clk edge where the FSM is in IDLE or DONE and ignored during RUN.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req, prog_sel         start request and program slot index
//   stall                 hold the PC this cycle (overrides halt and jumps)
//   absjump_en            load target as the new PC
//   reljump_en            add signed target to the PC
//   target                jump address / offset
//   halt_instr            halt opcode decoded at the current PC
//   prog_ctr              current fetch address
//   run, done, error      RUN state, DONE state, sticky fault
//   cycles                RUN cycles of the current/last run (saturating)
//   dbg_state             raw FSM state for observation
module fetch_sequencer
   import seq_pkg::*;
#(
   parameter int D   = 12,
   parameter int P   = 4,
   parameter int PSW = (P > 1) ? $clog2(P) : 1,
   parameter int CW  = 16,
   parameter logic [P*D-1:0] START_ADDR = {12'd600, 12'd400, 12'd200, 12'd0},
   parameter logic [P*D-1:0] END_ADDR   = {12'd700, 12'd500, 12'd300, 12'd160}
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req,
   input  logic [PSW-1:0] prog_sel,
   input  logic           stall,
   input  logic           absjump_en,
   input  logic           reljump_en,
   input  logic [D-1:0]   target,
   input  logic           halt_instr,
   output logic [D-1:0]   prog_ctr,
   output logic           run,
   output logic           done,
   output logic           error,
   output logic [CW-1:0]  cycles,
   output logic [1:0]     dbg_state
);

   seq_state_t     r_state, w_state_nxt;
   logic [PSW-1:0] r_sel_q, w_sel_nxt;
   logic [D-1:0]   r_pc, w_pc_nxt, w_pc_calc;
   logic [CW-1:0]  r_cycles, w_cycles_nxt;
   logic           r_error, w_error_nxt;
   pc_sel_t        w_pc_sel;
   logic           w_wrap, w_sel_ok, w_term;

   logic [D-1:0]   w_start_tab [P];
   logic [D-1:0]   w_end_tab   [P];

   for (genvar gi = 0; gi < P; gi++) begin : g_slot
      assign w_start_tab[gi] = START_ADDR[gi*D +: D];
      assign w_end_tab[gi]   = END_ADDR[gi*D +: D];
   end

   assign w_sel_ok = (int'(prog_sel) < P);
   assign w_term   = halt_instr | (r_pc >= w_end_tab[r_sel_q]);

   // Next-PC source; stall and termination both leave the PC where it is.
   always_comb begin
      w_pc_sel = PC_HOLD;
      if (r_state == RUN && !stall && !w_term) begin
         if (absjump_en)      w_pc_sel = PC_ABS;
         else if (reljump_en) w_pc_sel = PC_REL;
         else                 w_pc_sel = PC_INC;
      end
   end

   pc_next #(.D(D)) u_pc_next (
      .prog_ctr (r_pc),
      .target   (target),
      .sel      (w_pc_sel),
      .next_pc  (w_pc_calc),
      .wrap_err (w_wrap)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel_q;
      w_pc_nxt     = r_pc;
      w_cycles_nxt = r_cycles;
      w_error_nxt  = r_error;
      case (r_state)
         IDLE, DONE: begin
            if (req) begin
               if (w_sel_ok) begin
                  w_state_nxt  = RUN;
                  w_sel_nxt    = prog_sel;
                  w_pc_nxt     = w_start_tab[prog_sel];
                  w_cycles_nxt = '0;
                  w_error_nxt  = 1'b0;
               end else begin
                  w_state_nxt = DONE;
                  w_error_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (r_cycles != '1) w_cycles_nxt = r_cycles + CW'(1);
            if (!stall && w_term) begin
               w_state_nxt = DONE;
            end else if (w_wrap) begin
               w_state_nxt = DONE;
               w_error_nxt = 1'b1;
            end else begin
               w_pc_nxt = w_pc_calc;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_sel_q  <= '0;
         r_pc     <= '0;
         r_cycles <= '0;
         r_error  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel_q  <= w_sel_nxt;
         r_pc     <= w_pc_nxt;
         r_cycles <= w_cycles_nxt;
         r_error  <= w_error_nxt;
      end
   end

   assign prog_ctr  = r_pc;
   assign run       = (r_state == RUN);
   assign done      = (r_state == DONE);
   assign error     = r_error;
   assign cycles    = r_cycles;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a default 4-slot instance driven from a
// vector table, a 3-slot / 4-bit-counter instance for bad slot index, end at
// 12'hFFF and counter saturation, and a standalone pc_next for wrap cases
// that the sequencer's end test makes unreachable.
module tb_fetch_sequencer;
   import seq_pkg::*;

   localparam int D   = 12;
   localparam int CW  = 16;
   localparam int CWB = 4;
   localparam int OW  = D + CW + 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT A (default parameters) ----------------
   logic          req, stall, absjump_en, reljump_en, halt_instr;
   logic [1:0]    prog_sel;
   logic [D-1:0]  target;
   logic [D-1:0]  prog_ctr;
   logic          run, done, error;
   logic [CW-1:0] cycles;
   logic [1:0]    dbg_state;

   fetch_sequencer #(.D(D), .P(4), .CW(CW)) dut (
      .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .stall(stall),
      .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
      .halt_instr(halt_instr), .prog_ctr(prog_ctr), .run(run), .done(done),
      .error(error), .cycles(cycles), .dbg_state(dbg_state)
   );

   // ---------------- DUT B (P=3, end at 12'hFFF, narrow counter) ----------------
   logic           b_req, b_abs;
   logic [1:0]     b_sel;
   logic [D-1:0]   b_target;
   logic [D-1:0]   b_pc;
   logic           b_run, b_done, b_error;
   logic [CWB-1:0] b_cycles;
   logic [1:0]     b_dbg;

   fetch_sequencer #(
      .D(D), .P(3), .PSW(2), .CW(CWB),
      .START_ADDR({12'd400, 12'd200, 12'd0}),
      .END_ADDR  ({12'd500, 12'd300, 12'hFFF})
   ) dut_b (
      .clk(clk), .reset(reset), .req(b_req), .prog_sel(b_sel), .stall(1'b0),
      .absjump_en(b_abs), .reljump_en(1'b0), .target(b_target),
      .halt_instr(1'b0), .prog_ctr(b_pc), .run(b_run), .done(b_done),
      .error(b_error), .cycles(b_cycles), .dbg_state(b_dbg)
   );

   // ---------------- standalone pc_next ----------------
   logic [D-1:0] pn_pc, pn_tgt, pn_next;
   pc_sel_t      pn_sel;
   logic         pn_wrap;

   pc_next #(.D(D)) u_pn (
      .prog_ctr(pn_pc), .target(pn_tgt), .sel(pn_sel),
      .next_pc(pn_next), .wrap_err(pn_wrap)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic          req;
      logic [1:0]    sel;
      logic          stall, abs_en, rel_en;
      logic [D-1:0]  tgt;
      logic          halt;
      logic [D-1:0]  pc;
      logic          run, done, err;
      logic [CW-1:0] cyc;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [OW-1:0] obs_a();
      return {prog_ctr, run, done, error, cycles};
   endfunction

   function automatic logic [OW-1:0] obs_b();
      return {b_pc, b_run, b_done, b_error, {(CW-CWB){1'b0}}, b_cycles};
   endfunction

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got pc=%h run=%b done=%b err=%b cyc=%0d, want pc=%h run=%b done=%b err=%b cyc=%0d",
                  name, act[OW-1 -: D], act[CW+2], act[CW+1], act[CW], act[CW-1:0],
                  exp[OW-1 -: D], exp[CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic add(input logic rq, input logic [1:0] sl, input logic st, input logic ab,
                      input logic rl, input logic [D-1:0] tg, input logic hl,
                      input logic [D-1:0] pc, input logic rn, input logic dn, input logic er,
                      input logic [CW-1:0] cy);
      vec_t v;
      v.req = rq; v.sel = sl; v.stall = st; v.abs_en = ab; v.rel_en = rl; v.tgt = tg;
      v.halt = hl; v.pc = pc; v.run = rn; v.done = dn; v.err = er; v.cyc = cy;
      vecs.push_back(v);
   endtask

   // n quiet RUN cycles, each incrementing PC and cycle count
   task automatic add_plain(input int n, input logic [D-1:0] pc0, input logic [CW-1:0] cy0);
      for (int i = 1; i <= n; i++)
         add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, pc0 + D'(i), 1'b1, 1'b0, 1'b0, cy0 + CW'(i));
   endtask

   task automatic drive_a(input vec_t v);
      req = v.req; prog_sel = v.sel; stall = v.stall; absjump_en = v.abs_en;
      reljump_en = v.rel_en; target = v.tgt; halt_instr = v.halt;
   endtask

   task automatic idle_a();
      req = 1'b0; prog_sel = 2'd0; stall = 1'b0; absjump_en = 1'b0;
      reljump_en = 1'b0; target = '0; halt_instr = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pn(input string name, input pc_sel_t s, input logic [D-1:0] pc,
                         input logic [D-1:0] tg, input logic exp_wrap, input logic [D-1:0] exp_pc);
      pn_sel = s; pn_pc = pc; pn_tgt = tg;
      #1;
      check_val(name, {19'd0, pn_wrap, pn_next}, {19'd0, exp_wrap, exp_pc});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle_a();
      b_req = 1'b0; b_abs = 1'b0; b_sel = 2'd0; b_target = '0;
      pn_sel = PC_HOLD; pn_pc = '0; pn_tgt = '0;
      reset = 1'b1;
      #12;
      check("reset_a", obs_a(), '0);
      check_val("reset_state_a", 32'(dbg_state), 32'(IDLE));
      check("reset_b", obs_b(), '0);
      reset = 1'b0;
      tick();

      // pc_next wrap and selection cases
      chk_pn("pn_inc", PC_INC, 12'd5, 12'd0, 1'b0, 12'd6);
      chk_pn("pn_inc_wrap", PC_INC, 12'hFFF, 12'd0, 1'b1, 12'hFFF);
      chk_pn("pn_rel_back", PC_REL, 12'd410, 12'hFFB, 1'b0, 12'd405);
      chk_pn("pn_rel_under", PC_REL, 12'd10, 12'hF00, 1'b1, 12'd10);
      chk_pn("pn_rel_over", PC_REL, 12'hFF0, 12'h010, 1'b1, 12'hFF0);
      chk_pn("pn_rel_top", PC_REL, 12'hFF0, 12'h00F, 1'b0, 12'hFFF);
      chk_pn("pn_abs", PC_ABS, 12'd7, 12'hABC, 1'b0, 12'hABC);
      chk_pn("pn_hold", PC_HOLD, 12'd33, 12'hFFF, 1'b0, 12'd33);

      // DUT B: out-of-range slot, counter saturation, end at 12'hFFF
      b_req = 1'b1; b_sel = 2'd3;
      tick();
      check("b_bad_sel", obs_b(), {12'd0, 1'b0, 1'b1, 1'b1, 16'd0});
      b_sel = 2'd0;
      tick();
      check("b_start", obs_b(), {12'd0, 1'b1, 1'b0, 1'b0, 16'd0});
      b_req = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("b_saturate", obs_b(), {12'd20, 1'b1, 1'b0, 1'b0, 16'd15});
      b_abs = 1'b1; b_target = 12'hFFF;
      tick();
      check("b_abs_top", obs_b(), {12'hFFF, 1'b1, 1'b0, 1'b0, 16'd15});
      b_abs = 1'b0;
      tick();
      check("b_end_top", obs_b(), {12'hFFF, 1'b0, 1'b1, 1'b0, 16'd15});

      // DUT A vector table
      // program 0 straight run to its end address
      add(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      add_plain(160, 12'd0, 16'd0);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd160, 1'b0, 1'b1, 1'b0, 16'd161);
      // restart from DONE; stall masks halt, then halt terminates
      add(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      add_plain(5, 12'd0, 16'd0);
      add(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 12'd5, 1'b1, 1'b0, 1'b0, 16'd6);
      add(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 12'd5, 1'b1, 1'b0, 1'b0, 16'd7);
      add(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 12'd5, 1'b1, 1'b0, 1'b0, 16'd8);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 12'd5, 1'b0, 1'b1, 1'b0, 16'd9);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd5, 1'b0, 1'b1, 1'b0, 16'd9);
      // relative jump underflow
      add(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      add_plain(10, 12'd0, 16'd0);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b0, 12'd10, 1'b0, 1'b1, 1'b1, 16'd11);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd10, 1'b0, 1'b1, 1'b1, 16'd11);
      // program 2: back jump, abs-over-rel, req ignored in RUN, end at 500
      add(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd400, 1'b1, 1'b0, 1'b0, 16'd0);
      add_plain(10, 12'd400, 16'd0);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 12'hFFB, 1'b0, 12'd405, 1'b1, 1'b0, 1'b0, 16'd11);
      add(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 12'd450, 1'b0, 12'd450, 1'b1, 1'b0, 1'b0, 16'd12);
      add(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd451, 1'b1, 1'b0, 1'b0, 16'd13);
      add_plain(49, 12'd451, 16'd13);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd500, 1'b0, 1'b1, 1'b0, 16'd63);
      // program 3: forward jump past its end address
      add(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd600, 1'b1, 1'b0, 1'b0, 16'd0);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 12'h7FF, 1'b0, 12'd2647, 1'b1, 1'b0, 1'b0, 16'd1);
      add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd2647, 1'b0, 1'b1, 1'b0, 16'd2);

      foreach (vecs[i]) begin
         drive_a(vecs[i]);
         tick();
         check($sformatf("vec%0d", i), obs_a(),
               {vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].err, vecs[i].cyc});
      end
      idle_a();

      // asynchronous reset in the middle of a run
      req = 1'b1; prog_sel = 2'd0;
      tick();
      req = 1'b0;
      for (int i = 0; i < 77; i++) tick();
      check("pre_reset", obs_a(), {12'd77, 1'b1, 1'b0, 1'b0, 16'd77});
      #1 reset = 1'b1;
      #1;
      check("async_reset", obs_a(), '0);
      check_val("async_reset_state", 32'(dbg_state), 32'(IDLE));
      #1 reset = 1'b0;
      tick();
      check("post_reset_idle", obs_a(), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
